// File: rtl/skid_slice_pkg.sv
// Shared state encoding and flag decode for the registered skid slice.
// The tracker reuses the same 2-bit codes for its occupancy decode.
package skid_slice_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Registered handshake flags that accompany each state.
   typedef struct packed {
      logic       up_ready;
      logic       down_valid;
      logic [1:0] level;
   } flags_t;

   // Decode a state into its output flags; an unknown code reads as empty.
   function automatic flags_t decode_state(input logic [1:0] st);
      flags_t f;
      case (st)
         ST_BUSY: f = '{up_ready: 1'b1, down_valid: 1'b1, level: 2'd1};
         ST_FULL: f = '{up_ready: 1'b0, down_valid: 1'b1, level: 2'd2};
         default: f = '{up_ready: 1'b1, down_valid: 1'b0, level: 2'd0};
      endcase
      return f;
   endfunction

endpackage

// File: rtl/skid_slice.sv
// Fully registered valid/ready stage with a one-entry skid buffer.
// up_ready, down_valid, level and down_data all come straight from flops, so
// the stage cuts both the forward and the backward timing path of a link.
module skid_slice
   import skid_slice_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   input  logic [DW-1:0] up_data,
   output logic          up_ready,
   output logic          down_valid,
   output logic [DW-1:0] down_data,
   input  logic          down_ready,
   output logic [1:0]    level
);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   flags_t        flags_nxt;
   logic [DW-1:0] main_p1;
   logic [DW-1:0] skid_p1;
   logic          up_fire;
   logic          dn_fire;

   assign up_fire   = up_valid & up_ready;
   assign dn_fire   = down_valid & down_ready;
   assign down_data = main_p1;
   assign flags_nxt = decode_state(state_nxt);

   // Next-state selection from the two handshakes seen this cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (up_fire) state_nxt = ST_BUSY;
         ST_BUSY: begin
            if (up_fire && !dn_fire)      state_nxt = ST_FULL;
            else if (!up_fire && dn_fire) state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (dn_fire) state_nxt = ST_BUSY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // State register plus output flags registered from the next state's decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         up_ready   <= 1'b1;
         down_valid <= 1'b0;
         level      <= 2'd0;
      end else begin
         state      <= state_nxt;
         up_ready   <= flags_nxt.up_ready;
         down_valid <= flags_nxt.down_valid;
         level      <= flags_nxt.level;
      end
   end

   // ---- stage p1: main register feeds downstream, skid catches the overflow beat
   always_ff @(posedge clk) begin
      if (rst) begin
         main_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         case (state)
            ST_EMPTY: if (up_fire) main_p1 <= up_data;
            ST_BUSY: begin
               if (up_fire && dn_fire)       main_p1 <= up_data;
               else if (up_fire && !dn_fire) skid_p1 <= up_data;
            end
            ST_FULL:  if (dn_fire) main_p1 <= skid_p1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_skid_slice.sv
// Directed and randomized checks for the registered skid slice.
module tb_skid_slice;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_valid;
   logic [DW-1:0] up_data;
   logic          up_ready;
   logic          down_valid;
   logic [DW-1:0] down_data;
   logic          down_ready;
   logic [1:0]    level;

   int n_vec  = 0;
   int n_miss = 0;
   bit forbidden_seen = 1'b0;

   skid_slice #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (up_ready),
      .down_valid (down_valid),
      .down_data  (down_data),
      .down_ready (down_ready),
      .level      (level)
   );

   always #5 clk = ~clk;

   // Payloads that were pushed only during/just before a reset must never leave the stage.
   always @(posedge clk) begin
      if (!rst && down_valid && down_ready &&
          (down_data == 16'hDEAD || down_data == 16'h0011 ||
           down_data == 16'h0022 || down_data == 16'h0033))
         forbidden_seen <= 1'b1;
   end

   typedef struct {
      logic          rst;
      logic          uv;
      logic [DW-1:0] ud;
      logic          dr;
      logic          e_ur;
      logic          e_dv;
      logic [DW-1:0] e_dd;
      logic          chk_dd;
      logic [1:0]    e_lvl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic uv, input logic [DW-1:0] ud, input logic dr,
                      input logic eur, input logic edv, input logic [DW-1:0] edd,
                      input logic cdd, input logic [1:0] elvl);
      vec_t v;
      v = '{rst: r, uv: uv, ud: ud, dr: dr, e_ur: eur, e_dv: edv, e_dd: edd,
            chk_dd: cdd, e_lvl: elvl};
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic uv, input logic [DW-1:0] ud, input logic dr);
      rst = r; up_valid = uv; up_data = ud; down_ready = dr;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [DW-1:0] q[$];
      int            cnt;
      logic          uf, df;

      drive(1'b1, 1'b0, '0, 1'b0);

      //   rst uv  ud       dr   ur  dv  dd       chk lvl
      add(1, 1, 16'hDEAD, 0,   1, 0, 16'h0000, 1, 0); // 0 reset with traffic
      add(1, 1, 16'hDEAD, 0,   1, 0, 16'h0000, 1, 0);
      add(1, 1, 16'hDEAD, 0,   1, 0, 16'h0000, 1, 0);
      add(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 1, 0); // 3 idle after release
      add(0, 1, 16'h00A0, 0,   1, 1, 16'h00A0, 1, 1); // 4 EMPTY -> BUSY
      add(0, 1, 16'h00A1, 0,   0, 1, 16'h00A0, 1, 2); // 5 BUSY -> FULL, main stable
      add(0, 1, 16'h00A2, 0,   0, 1, 16'h00A0, 1, 2); // 6 FULL ignores up_valid
      add(0, 1, 16'h00A2, 1,   1, 1, 16'h00A1, 1, 1); // 7 A0 out, skid -> main
      add(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0); // 8 A1 out, EMPTY
      add(0, 1, 16'h0055, 1,   1, 1, 16'h0055, 1, 1); // 9 load 55
      add(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0); // 10 drain 55
      add(0, 1, 16'h0011, 0,   1, 1, 16'h0011, 1, 1); // 11
      add(0, 1, 16'h0022, 0,   0, 1, 16'h0011, 1, 2); // 12 FULL 11/22
      add(1, 1, 16'h0033, 1,   1, 0, 16'h0000, 1, 0); // 13 reset wins over both fires
      add(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 1, 0); // 14
      add(0, 1, 16'hBEEF, 1,   1, 1, 16'hBEEF, 1, 1); // 15
      add(0, 1, 16'hC0DE, 1,   1, 1, 16'hC0DE, 1, 1); // 16 streaming in BUSY
      add(0, 1, 16'h1234, 0,   0, 1, 16'hC0DE, 1, 2); // 17
      add(0, 0, 16'h0000, 1,   1, 1, 16'h1234, 1, 1); // 18 FULL -> BUSY
      add(0, 0, 16'h0000, 0,   1, 1, 16'h1234, 1, 1); // 19 hold
      add(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0, 0); // 20 drain

      foreach (vecs[i]) begin
         logic [DW-1:0] act_dd, exp_dd;
         drive(vecs[i].rst, vecs[i].uv, vecs[i].ud, vecs[i].dr);
         step();
         act_dd = vecs[i].chk_dd ? down_data : '0;
         exp_dd = vecs[i].chk_dd ? vecs[i].e_dd : '0;
         n_vec++;
         if ({up_ready, down_valid, level, act_dd} !==
             {vecs[i].e_ur, vecs[i].e_dv, vecs[i].e_lvl, exp_dd}) begin
            n_miss++;
            $display("FAIL vec%0d: got ur=%b dv=%b lvl=%0d dd=%h expected ur=%b dv=%b lvl=%0d dd=%h",
                     i, up_ready, down_valid, level, act_dd,
                     vecs[i].e_ur, vecs[i].e_dv, vecs[i].e_lvl, exp_dd);
         end
      end

      // Back-to-back stream 0x0001..0x0010 with downstream always ready.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b1, DW'(i), 1'b1);
         step();
         check($sformatf("stream%0d", i), {13'd0, up_ready, down_valid, level, down_data},
               {13'd0, 1'b1, 1'b1, 2'd1, DW'(i)});
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      step();
      check("stream_drain", {up_ready, down_valid, level}, {1'b1, 1'b0, 2'd0});

      // Random valid/backpressure against an in-order queue model.
      cnt = 0;
      for (int c = 0; c < 10000; c++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(16'h1000, 16'h7FFF)),
               1'($urandom_range(0, 1)));
         #1;
         uf = up_valid && up_ready;
         df = down_valid && down_ready;
         if (df) begin
            if (q.size() == 0) check("rnd_pop_empty", 32'd1, 32'd0);
            else check($sformatf("rnd_data c%0d", c), {16'd0, down_data}, {16'd0, q.pop_front()});
         end
         if (uf) q.push_back(up_data);
         cnt = q.size();
         @(posedge clk);
         #1;
         check($sformatf("rnd_flags c%0d", c), {29'd0, up_ready, down_valid, level},
               {29'd0, (cnt < 2), (cnt > 0), 2'(cnt)});
      end

      // Drain whatever the random phase left behind.
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         #1;
         if (down_valid) begin
            if (q.size() == 0) check("tail_pop_empty", 32'd1, 32'd0);
            else check("tail_data", {16'd0, down_data}, {16'd0, q.pop_front()});
         end
         step();
      end
      check("tail_empty", {30'd0, down_valid, 1'b0} | 32'(q.size()), 32'd0);
      check("no_forbidden_emitted", {31'd0, forbidden_seen}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
